// File: rtl/sl_receiver_fifo.sv
// Two-line self-clocking serial receiver: decodes parity-protected frames of
// configurable length and queues good words in a small FIFO with sticky status.
module sl_receiver_fifo #(
  parameter int MAX_BITS = 32,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_line_zeroes_a,
  input  logic                serial_line_ones_a,
  input  logic                wr_enable,
  input  logic [15:0]         wr_config_w,
  output logic [15:0]         r_config_w,
  input  logic                rd_en,
  input  logic                status_clr,
  output logic [MAX_BITS-1:0] data_w,
  output logic [15:0]         status_w
);

  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CW   = AW + 1;
  localparam logic [6:0] NMAX = 7'(MAX_BITS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Index 0 carries the zeroes line, index 1 the ones line.
  logic [1:0] r_meta, r_cur, r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 2'b11;
      r_cur  <= 2'b11;
      r_prev <= 2'b11;
    end else begin
      r_meta <= {serial_line_ones_a, serial_line_zeroes_a};
      r_cur  <= r_meta;
      r_prev <= r_cur;
    end
  end

  logic [1:0] w_fall;
  logic       w_ev_zero, w_ev_one, w_ev_stop, w_ev_single, w_ev_any;

  assign w_fall      = r_prev & ~r_cur;
  assign w_ev_zero   = w_fall[0] & r_cur[1];
  assign w_ev_one    = w_fall[1] & r_cur[0];
  assign w_ev_stop   = ~r_cur[0] & ~r_cur[1] & (|w_fall);
  assign w_ev_single = w_ev_zero | w_ev_one;
  assign w_ev_any    = w_ev_single | w_ev_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_config_w <= 16'h0010;
    end else if (wr_enable) begin
      r_config_w <= wr_config_w & 16'hFFFE;
    end
  end

  logic [6:0]  w_l_even, w_n_cfg;
  logic [11:0] w_to_limit;

  assign w_l_even   = {r_config_w[7:2], 1'b0};
  assign w_n_cfg    = (w_l_even < 7'd2) ? 7'd2 : ((w_l_even > NMAX) ? NMAX : w_l_even);
  assign w_to_limit = {r_config_w[15:8], 4'b0000};

  state_t              r_state;
  logic [6:0]          r_n, r_cnt;
  logic [MAX_BITS-1:0] r_word;
  logic                r_zpar, r_opar, r_rp0, r_rp1;
  logic [11:0]         r_to;

  logic [MAX_BITS-1:0] w_bit_mask;
  logic                w_timeout, w_stop_done, w_par_ok;
  logic                w_push_req, w_perr_set, w_lerr_set;

  assign w_bit_mask  = {{(MAX_BITS-1){1'b0}}, 1'b1} << r_cnt;
  // Any event in the same cycle restarts the timer, so it beats a timeout.
  assign w_timeout   = (r_state != S_IDLE) && (r_config_w[15:8] != 8'd0) &&
                       (r_to >= w_to_limit) && !w_ev_any;
  assign w_stop_done = (r_state == S_STOP) && w_ev_stop;
  assign w_par_ok    = (r_rp0 == r_zpar) && (r_rp1 == ~r_opar);
  assign w_push_req  = w_stop_done && w_par_ok;
  assign w_perr_set  = w_stop_done && !w_par_ok;
  assign w_lerr_set  = (((r_state == S_DATA) || (r_state == S_PARITY)) && w_ev_stop) ||
                       ((r_state == S_STOP) && w_ev_single);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_n     <= 7'd8;
      r_cnt   <= '0;
      r_word  <= '0;
      r_zpar  <= 1'b0;
      r_opar  <= 1'b0;
      r_rp0   <= 1'b0;
      r_rp1   <= 1'b0;
      r_to    <= '0;
    end else begin
      if ((r_state == S_IDLE) || w_ev_any) begin
        r_to <= '0;
      end else if (r_to != 12'hFFF) begin
        r_to <= r_to + 12'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_ev_single) begin
            r_n     <= w_n_cfg;
            r_cnt   <= 7'd1;
            r_word  <= {{(MAX_BITS-1){1'b0}}, w_ev_one};
            r_zpar  <= w_ev_zero;
            r_opar  <= w_ev_one;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_ev_single) begin
            if (w_ev_one) r_word <= r_word | w_bit_mask;
            r_cnt  <= r_cnt + 7'd1;
            r_zpar <= r_zpar ^ w_ev_zero;
            r_opar <= r_opar ^ w_ev_one;
            if (r_cnt + 7'd1 == r_n) r_state <= S_PARITY;
          end else if (w_ev_stop || w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        S_PARITY: begin
          if (w_ev_single) begin
            r_rp0   <= w_ev_one;
            r_rp1   <= w_ev_zero;
            r_state <= S_STOP;
          end else if (w_ev_stop || w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        S_STOP: begin
          if (w_ev_any || w_timeout) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [MAX_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_count;
  logic [MAX_BITS-1:0] r_head;
  logic                r_perr, r_lerr, r_terr, r_ovf;

  logic                w_full, w_empty, w_pop, w_push, w_drop;
  logic [AW-1:0]       w_rp_next;
  logic [CW-1:0]       w_count_next;
  logic [MAX_BITS-1:0] w_head_next;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_pop        = rd_en && !w_empty;
  assign w_push       = w_push_req && (!w_full || w_pop);
  assign w_drop       = w_push_req && w_full && !w_pop;
  assign w_rp_next    = w_pop ? (r_rp + AW'(1)) : r_rp;
  assign w_count_next = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
  // Head register bypasses the array when the word being written becomes the head.
  assign w_head_next  = (w_count_next == '0) ? '0 :
                        ((w_push && (r_wp == w_rp_next)) ? r_word : r_mem[w_rp_next]);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= r_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_head  <= '0;
      r_perr  <= 1'b0;
      r_lerr  <= 1'b0;
      r_terr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      r_rp    <= w_rp_next;
      r_count <= w_count_next;
      r_head  <= w_head_next;
      r_perr  <= w_perr_set | (r_perr & ~status_clr);
      r_lerr  <= w_lerr_set | (r_lerr & ~status_clr);
      r_terr  <= w_timeout  | (r_terr & ~status_clr);
      r_ovf   <= w_drop     | (r_ovf  & ~status_clr);
    end
  end

  assign data_w   = r_head;
  assign status_w = {4'b0000, 4'(r_count), 1'b0, (r_state != S_IDLE), r_ovf,
                     w_full, !w_empty, r_terr, r_lerr, r_perr};

endmodule

// File: tb/tb_sl_receiver_fifo.sv
// Randomised bench for sl_receiver_fifo: a frame-level model predicts pushed words
// and status; a monitor pops the FIFO and scores every presented word.
module tb_sl_receiver_fifo;

  localparam int MAXB = 32;
  localparam int DEP  = 4;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        line_z     = 1'b1;
  logic        line_o     = 1'b1;
  logic        wr_enable  = 1'b0;
  logic [15:0] wr_cfg     = 16'h0000;
  logic [15:0] cfg_rd;
  logic        stim_rd    = 1'b0;
  logic        mon_rd     = 1'b0;
  logic        rd_en;
  logic        status_clr = 1'b0;
  logic [MAXB-1:0] data_w;
  logic [15:0] status_w;

  assign rd_en = stim_rd | mon_rd;

  sl_receiver_fifo #(.MAX_BITS(MAXB), .DEPTH(DEP)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .serial_line_zeroes_a (line_z),
    .serial_line_ones_a   (line_o),
    .wr_enable            (wr_enable),
    .wr_config_w          (wr_cfg),
    .r_config_w           (cfg_rd),
    .rd_en                (rd_en),
    .status_clr           (status_clr),
    .data_w               (data_w),
    .status_w             (status_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [15:0] status;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_fifo[$];
  logic [15:0] m_sticky = 16'h0000;
  bit          auto_pop = 1'b0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int eff_n(input int l);
    int n;
    n = (l / 2) * 2;
    if (n < 2) n = 2;
    if (n > MAXB) n = MAXB;
    return n;
  endfunction

  function automatic logic [15:0] exp_status(input int cnt);
    logic [15:0] s;
    s = m_sticky;
    s[11:8] = 4'(cnt);
    if (cnt > 0) s[3] = 1'b1;
    if (cnt == DEP) s[4] = 1'b1;
    return s;
  endfunction

  task automatic write_cfg(input int t, input int l);
    wr_cfg    = {8'(t), 7'(l), 1'b1};
    wr_enable = 1'b1;
    @(negedge clk);
    wr_enable = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    if (b) line_o = 1'b0;
    else   line_z = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    line_o = 1'b1;
    line_z = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // The stop event is acted on at the third rising edge after both lines drop.
  task automatic send_stop(input bit pop_at_stop);
    line_z = 1'b0;
    line_o = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (pop_at_stop) stim_rd = 1'b1;
    @(negedge clk);
    stim_rd = 1'b0;
    line_z  = 1'b1;
    line_o  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] w, input int n, input bit par_ok, input bit pop_at_stop);
    int zeros;
    bit p;
    zeros = 0;
    for (int i = 0; i < n; i++) begin
      if (!w[i]) zeros++;
      send_bit(w[i]);
    end
    p = (zeros % 2) != 0;
    if (!par_ok) p = !p;
    send_bit(p);
    send_stop(pop_at_stop);
    $display("frame n=%0d word=%08h parity_ok=%0d", n, w, par_ok);
  endtask

  function automatic logic [31:0] rand_word(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return $urandom & m[31:0];
  endfunction

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic good_frame(input int l);
    exp_t        e;
    logic [31:0] w;
    int          n;
    write_cfg(0, l);
    check("cfg_readback", cfg_rd, {8'd0, 7'(l), 1'b0});
    n = eff_n(l);
    w = rand_word(n);
    e.data   = w;
    e.status = exp_status(1);
    exp_q.push_back(e);
    send_frame(w, n, 1'b1, 1'b0);
    wait_drain();
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    m_sticky = 16'h0000;
  endtask

  // Monitor: whenever a word is presented and draining is enabled, score and pop it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (auto_pop && !rst && status_w[3]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got %08h, expected no word", data_w);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", data_w, e.data);
          check("pop_status", status_w, e.status);
          $display("pop data=%08h status=%04h", data_w, status_w);
        end
        mon_rd = 1'b1;
        @(negedge clk);
        mon_rd = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    exp_t        e;

    repeat (3) @(negedge clk);
    check("reset_status", status_w, 16'h0000);
    check("reset_data", data_w, 32'h0);
    check("reset_cfg", cfg_rd, 16'h0010);
    rst = 1'b0;
    @(negedge clk);
    auto_pop = 1'b1;

    // Fixed 0xA5 frame at the default configuration.
    e.data   = 32'h000000A5;
    e.status = exp_status(1);
    exp_q.push_back(e);
    send_frame(32'hA5, 8, 1'b1, 1'b0);
    wait_drain();

    // Every even length, then odd/out-of-range lengths that round and clamp.
    for (int l = 8; l <= MAXB; l += 2) good_frame(l);
    good_frame(9);
    good_frame(5);
    good_frame(0);
    good_frame(100);

    // Inverted parity.
    write_cfg(0, 16);
    send_frame(rand_word(16), 16, 1'b0, 1'b0);
    m_sticky[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("parity_err", status_w, exp_status(0));
    pulse_clr();
    check("parity_clr", status_w, exp_status(0));

    // Stop after 10 of 16 bits.
    w = rand_word(16);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
    send_stop(1'b0);
    m_sticky[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("len_short", status_w, exp_status(0));
    pulse_clr();

    // Extra bit after parity; the trailing stop lands in IDLE and is ignored.
    w = rand_word(16);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
    send_bit(1'b0);
    send_bit(1'b1);
    send_stop(1'b0);
    m_sticky[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("len_extra", status_w, exp_status(0));
    pulse_clr();
    check("len_clr", status_w, exp_status(0));

    // Overflow: five frames into a four-deep FIFO without popping.
    auto_pop = 1'b0;
    repeat (3) @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      w = rand_word(16);
      send_frame(w, 16, 1'b1, 1'b0);
      if (m_fifo.size() < DEP) m_fifo.push_back(w);
      else m_sticky[5] = 1'b1;
    end
    check("ovf_count", status_w[11:8], m_fifo.size());
    check("ovf_status", status_w, exp_status(m_fifo.size()));
    check("ovf_head", data_w, m_fifo[0]);

    // Pop and push on the same edge while full.
    w = rand_word(16);
    send_frame(w, 16, 1'b1, 1'b1);
    void'(m_fifo.pop_front());
    m_fifo.push_back(w);
    check("popush_status", status_w, exp_status(m_fifo.size()));
    check("popush_head", data_w, m_fifo[0]);

    for (int i = 0; i < m_fifo.size(); i++) begin
      e.data   = m_fifo[i];
      e.status = exp_status(m_fifo.size() - i);
      exp_q.push_back(e);
    end
    m_fifo.delete();
    auto_pop = 1'b1;
    wait_drain();
    pulse_clr();
    check("drained_status", status_w, exp_status(0));

    // Timeout with T=1: error 17 cycles after the last synchronised event.
    write_cfg(1, 16);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    line_z = 1'b0;
    repeat (2) @(negedge clk);
    line_z = 1'b1;
    repeat (17) @(negedge clk);
    check("timeout_not_yet", status_w, 16'h0040);
    @(negedge clk);
    m_sticky[2] = 1'b1;
    check("timeout_err", status_w, exp_status(0));

    // Reset in the middle of a frame.
    write_cfg(0, 8);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_sticky = 16'h0000;
    check("rst_status", status_w, 16'h0000);
    check("rst_cfg", cfg_rd, 16'h0010);
    check("rst_data", data_w, 32'h0);
    @(negedge clk);
    good_frame(8);

    repeat (10) @(negedge clk);
    check("final_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sl_receiver_fifo.md
SL_RECEIVER_FIFO -- requirements
Module: sl_receiver_fifo

Parameters
REQ-001 SHALL provide MAX_BITS, default 32: maximum word length; even, 8..64.
REQ-002 SHALL provide DEPTH, default 4: receive FIFO depth in words; power of two, 2..8.

Interface
REQ-003 SHALL have clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have serial_line_zeroes_a  in  1  asynchronous zeroes line, idle high.
REQ-006 SHALL have serial_line_ones_a  in  1  asynchronous ones line, idle high.
REQ-007 SHALL have wr_enable  in  1  one-cycle config write strobe.
REQ-008 SHALL have wr_config_w  in  16  config write data.
REQ-009 SHALL have r_config_w  out  16  current config register.
REQ-010 SHALL have rd_en  in  1  pop FIFO head.
REQ-011 SHALL have status_clr  in  1  clear sticky status bits.
REQ-012 SHALL have data_w  out  MAX_BITS  FIFO head word, zero when empty.
REQ-013 SHALL have status_w  out  16  status word.

Function
REQ-014 Both lines SHALL pass through 2-flop synchronisers; all events below use synchronised samples (cur, prev).
REQ-015 Single-line event: line falls (prev=1, cur=0) while the other line's cur=1. Stop event: both cur=0 with at least one falling.
REQ-016 Config: [7:1] bit count L, [15:8] timeout T; bit 0 reads 0. Effective N = L rounded down to even, clamped to 2..MAX_BITS. N is latched at frame start; writes mid-frame apply to the next frame.
REQ-017 FSM states: IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: single-line event stores bit 0 (zeroes line -> 0, ones line -> 1), bits LSB first -> DATA. Stop event in IDLE ignored.
REQ-019 DATA: each single-line event stores the next bit; on the Nth bit -> PARITY. Stop event -> length error -> IDLE.
REQ-020 PARITY: single-line event records received parity (zeroes line low -> rp0=0, rp1=1; ones line low -> rp0=1, rp1=0) -> STOP. Stop event -> length error -> IDLE.
REQ-021 STOP: stop event -> parity check -> IDLE. Single-line event -> length error -> IDLE.
REQ-022 Expected parity: e0 = (number of zeros) mod 2; e1 = 1 XOR ((number of ones) mod 2). Parity error when rp0!=e0 or rp1!=e1.
REQ-023 Word: bit i = i-th received bit; bits N..MAX_BITS-1 are zero.
REQ-024 Timeout: outside IDLE, a counter resets on every event. At T*16 cycles -> timeout error -> IDLE. T=0 disables timeout.
REQ-025 Error-free frame: word pushed at stop cycle S; data_w and status_w[3] valid at S+1.
REQ-026 Errored frames are never pushed.
REQ-027 Push when full without same-cycle rd_en: word dropped, overflow set. Push with same-cycle rd_en when full: pop then push, both succeed.
REQ-028 rd_en when empty: ignored.
REQ-029 status_w: [0] parity err, [1] length err, [2] timeout err, [3] FIFO not empty, [4] FIFO full, [5] overflow, [6] busy (state!=IDLE), [11:8] FIFO count, others 0.
REQ-030 Bits [0],[1],[2],[5] SHALL be sticky until status_clr. A same-cycle set wins over clear.

Reset
REQ-031 rst SHALL force: state IDLE, FIFO empty, data_w=0, status_w=0, config N=8 / T=0 (r_config_w=16'h0010), synchronisers=1, counters 0.
REQ-032 rst mid-frame SHALL discard the partial frame. No FIFO push occurs.

Verification
REQ-033 Config 16'h0010, send 8 bits 0xA5, correct parity, stop -> data_w=0x000000A5, status_w=16'h0108.
REQ-034 For L=8,10,...,MAX_BITS, random word, correct parity, pop between frames -> data_w = sent word, status_w=16'h0108.
REQ-035 N=16, parity lines inverted -> FIFO unchanged, status_w[0]=1. status_clr -> status_w[0]=0.
REQ-036 N=16, stop after 10 bits -> status_w[1]=1, no push. N=16, extra bit after parity -> status_w[1]=1.
REQ-037 DEPTH=4: five good frames with no pop -> count=4, full=1, overflow=1, data_w = first word. Pop + push in the same cycle -> count stays 4.
REQ-038 T=1, stall 20 cycles mid-DATA -> status_w[2]=1, busy=0 at cycle 17 after the last event. rst mid-frame -> status_w=0.
